card_display_bank: RTL

- Registered, multi-channel successor to the single-digit combinational card decoder.
- Holds NUM_CH card codes, one per table slot (default 6: player cards 1-3, dealer cards 1-3), and drives one 7-segment digit per slot.
- A newly loaded card blinks for a programmable number of periods and then shows steadily.
- Sits between the datapath card registers and the HEX outputs; a polarity parameter selects active-low (board) or active-high segments.

---
 rtl/card_disp_pkg.sv | 68 ++++++
 rtl/card_digit.sv | 101 ++++++++++
 rtl/card_display_bank.sv | 39 +++
 3 files changed

// File: rtl/card_disp_pkg.sv
// Shared definitions for the card display bank.
// Provides the card code type, named card codes, active-low segment patterns
// and the code-to-segment decode function. Segment bit 6 = g, bit 0 = a.
package card_disp_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;

  typedef logic [CODE_W-1:0] card_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } digit_state_e;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TWO   = 4'd2;
  localparam card_t CARD_THREE = 4'd3;
  localparam card_t CARD_FOUR  = 4'd4;
  localparam card_t CARD_FIVE  = 4'd5;
  localparam card_t CARD_SIX   = 4'd6;
  localparam card_t CARD_SEVEN = 4'd7;
  localparam card_t CARD_EIGHT = 4'd8;
  localparam card_t CARD_NINE  = 4'd9;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;

  // Active-low patterns: 0 lights the segment.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ACE   = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_TWO   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_THREE = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_FOUR  = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_FIVE  = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_SIX   = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_SEVEN = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_EIGHT = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_NINE  = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_TEN   = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_JACK  = 7'b1100001;
  localparam logic [SEG_W-1:0] SEG_QUEEN = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_KING  = 7'b0001001;

  // Code to active-low pattern; unused codes show blank.
  function automatic logic [SEG_W-1:0] decode_card(input card_t code);
    case (code)
      CARD_ACE:   return SEG_ACE;
      CARD_TWO:   return SEG_TWO;
      CARD_THREE: return SEG_THREE;
      CARD_FOUR:  return SEG_FOUR;
      CARD_FIVE:  return SEG_FIVE;
      CARD_SIX:   return SEG_SIX;
      CARD_SEVEN: return SEG_SEVEN;
      CARD_EIGHT: return SEG_EIGHT;
      CARD_NINE:  return SEG_NINE;
      CARD_TEN:   return SEG_TEN;
      CARD_JACK:  return SEG_JACK;
      CARD_QUEEN: return SEG_QUEEN;
      CARD_KING:  return SEG_KING;
      default:    return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/card_digit.sv
// One card slot: code register, blink FSM, half-period and pair counters,
// and the registered segment/busy outputs.
// Ports: clk, reset (sync, active-high), load/card_in (capture strobe + code),
// clear (blank and stop), seg7 (7 segments, polarity per ACTIVE_LOW), busy.
module card_digit
  import card_disp_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] card_in,
  input  logic       clear,
  output logic [6:0] seg7,
  output logic       busy
);

  localparam int unsigned HW = $clog2(BLINK_DIV + 1);
  // A zero-width pair counter is not legal, keep at least one bit.
  localparam int unsigned PW = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(BLINK_COUNT - 1);
  localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  digit_state_e     state_q;
  card_t            code_q;
  logic [HW-1:0]    half_q;
  logic [PW-1:0]    pair_q;
  logic [SEG_W-1:0] seg_q;
  logic             busy_q;

  // Apply output polarity to a decoded code.
  function automatic logic [SEG_W-1:0] show(input card_t c);
    return ACTIVE_LOW ? decode_card(c) : ~decode_card(c);
  endfunction

  // Outputs are loaded with the value for the state being entered, so they
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
      code_q  <= CARD_BLANK;
      half_q  <= '0;
      pair_q  <= '0;
      seg_q   <= SEG_OFF;
      busy_q  <= 1'b0;
    end else if (load) begin
      code_q <= card_in;
      half_q <= '0;
      pair_q <= '0;
      seg_q  <= show(card_in);
      if (BLINK_COUNT == 0) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        state_q <= ST_ON;
        busy_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_ON: begin
          if (half_q == HALF_LAST) begin
            state_q <= ST_OFF;
            half_q  <= '0;
            seg_q   <= SEG_OFF;
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        ST_OFF: begin
          if (half_q == HALF_LAST) begin
            half_q <= '0;
            seg_q  <= show(code_q);
            if (pair_q == PAIR_LAST) begin
              state_q <= ST_IDLE;
              pair_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_ON;
              pair_q  <= pair_q + PW'(1);
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          seg_q   <= show(code_q);
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign seg7 = seg_q;
  assign busy = busy_q;

endmodule

// File: rtl/card_display_bank.sv
// Multi-slot registered card display: one blinking 7-segment digit per slot.
// Ports: clk, reset (sync, active-high), load[NUM_CH] strobes,
// card_in[4*NUM_CH] codes (slot i at [4i+3:4i]), clear (new hand),
// seg7[7*NUM_CH] segments (slot i at [7i+6:7i]), busy[NUM_CH] blinking flags.
module card_display_bank
  import card_disp_pkg::*;
#(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned BLINK_COUNT = 3,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     load,
  input  logic [4*NUM_CH-1:0]   card_in,
  input  logic                  clear,
  output logic [7*NUM_CH-1:0]   seg7,
  output logic [NUM_CH-1:0]     busy
);

  // Independent digit per slot; only bus slicing happens here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    card_digit #(
      .BLINK_DIV  (BLINK_DIV),
      .BLINK_COUNT(BLINK_COUNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .load   (load[i]),
      .card_in(card_in[CODE_W*i +: CODE_W]),
      .clear  (clear),
      .seg7   (seg7[SEG_W*i +: SEG_W]),
      .busy   (busy[i])
    );
  end

endmodule
